// File: rtl/ifid_pkg.sv
// Shared types and constants for the IF/ID stage register.
// State codes are {main_v, skid_v}; the beat struct is the default-width payload.
package ifid_pkg;

   localparam int DEF_PC_W   = 32;
   localparam int DEF_INST_W = 32;

   localparam logic [DEF_INST_W-1:0] NOP_INST_DEF = 32'h0000_0000;

   localparam logic [1:0] EMPTY = 2'b00;
   localparam logic [1:0] ONE   = 2'b10;
   localparam logic [1:0] FULL  = 2'b11;

   typedef struct packed {
      logic [DEF_PC_W-1:0]   pc;
      logic [DEF_INST_W-1:0] inst;
   } ifid_beat_t;

endpackage

// File: rtl/ifid_pipe_stage_sat_counter.sv
// Saturating up-counter used for per-stage performance statistics.
// Holds at all-ones instead of wrapping; only reset clears it.
module sat_counter #(
   parameter int CNT_W = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             inc_i,
   output logic [CNT_W-1:0] cnt_o
);

   logic [CNT_W-1:0] r_cnt;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_cnt <= '0;
      end else if (inc_i && (r_cnt != {CNT_W{1'b1}})) begin
         r_cnt <= r_cnt + CNT_W'(1);
      end
   end

   assign cnt_o = r_cnt;

endmodule

// File: rtl/ifid_pipe_stage.sv
// IF/ID stage register with a two-entry (main + skid) buffer so that both
// in_ready_o and out_valid_o come straight from flops.
module ifid_pipe_stage
   import ifid_pkg::*;
#(
   parameter int                 PC_W     = 32,
   parameter int                 INST_W   = 32,
   parameter logic [INST_W-1:0]  NOP_INST = INST_W'(NOP_INST_DEF),
   parameter int                 CNT_W    = 16
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              flush_i,
   input  logic              in_valid_i,
   output logic              in_ready_o,
   input  logic [PC_W-1:0]   in_pc_i,
   input  logic [INST_W-1:0] in_inst_i,
   output logic              out_valid_o,
   input  logic              out_ready_i,
   output logic [PC_W-1:0]   out_pc_o,
   output logic [INST_W-1:0] out_inst_o,
   output logic [CNT_W-1:0]  stall_cnt_o
);

   typedef struct packed {
      logic [PC_W-1:0]   pc;
      logic [INST_W-1:0] inst;
   } beat_t;

   beat_t r_main;
   beat_t r_skid;
   logic  r_main_v;
   logic  r_skid_v;
   logic  r_in_ready;

   beat_t      w_in_beat;
   logic       w_push;
   logic       w_pop;
   logic [1:0] w_state;

   assign w_in_beat = '{pc: in_pc_i, inst: in_inst_i};
   assign w_push    = in_valid_i & r_in_ready;
   assign w_pop     = r_main_v & out_ready_i;
   assign w_state   = {r_main_v, r_skid_v};

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_main_v   <= 1'b0;
         r_skid_v   <= 1'b0;
         r_in_ready <= 1'b1;
         r_main     <= '{pc: '0, inst: NOP_INST};
         r_skid     <= '0;
      end else if (flush_i) begin
         // Decode has already taken any beat popped this cycle, so dropping
         // everything is safe; the PC field carries the redirect target.
         r_main_v   <= 1'b0;
         r_skid_v   <= 1'b0;
         r_in_ready <= 1'b1;
         r_main.pc  <= in_pc_i;
      end else begin
         case (w_state)
            EMPTY: begin
               if (w_push) begin
                  r_main   <= w_in_beat;
                  r_main_v <= 1'b1;
               end
            end
            ONE: begin
               if (w_push && w_pop) begin
                  r_main <= w_in_beat;
               end else if (w_push) begin
                  r_skid     <= w_in_beat;
                  r_skid_v   <= 1'b1;
                  r_in_ready <= 1'b0;
               end else if (w_pop) begin
                  r_main_v <= 1'b0;
               end
            end
            FULL: begin
               if (w_pop) begin
                  r_main     <= r_skid;
                  r_skid_v   <= 1'b0;
                  r_in_ready <= 1'b1;
               end
            end
            default: begin
               r_skid_v   <= 1'b0;
               r_in_ready <= 1'b1;
            end
         endcase
      end
   end

   assign in_ready_o  = r_in_ready;
   assign out_valid_o = r_main_v;
   assign out_pc_o    = r_main.pc;
   assign out_inst_o  = r_main_v ? r_main.inst : NOP_INST;

   sat_counter #(
      .CNT_W (CNT_W)
   ) u_stall_cnt (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .inc_i (r_main_v & ~out_ready_i),
      .cnt_o (stall_cnt_o)
   );

endmodule
